ph_burst_fifo: RTL and testbench
================================

// Module: ph_burst_fifo
// PURPOSE
// - Parametrised parasite-to-host data FIFO for Tube register 3 block transfers; successor to the fixed 2-byte R3 latch.
// - Depth, width and burst size are generic; one-byte mode makes it behave as a single-entry latch.
// - Burst mode gives hysteresis: "not full" stays high until a whole burst is written; "available" stays high until fully drained.
// - Sits between the parasite write port and the host read port. Its flags drive PNMI/N/DRQ in the status logic.
// PARAMETERS
// - WIDTH       8      data width in bits
// - DEPTH       4      storage entries, >=2, power of two
// - BURST       2      entries per burst in burst mode, 2..DEPTH
// - RESET_PRIME 1      1: reset leaves one entry (RESET_BYTE) queued, which suppresses a spurious PNMI; 0: reset leaves the FIFO empty
// - RESET_BYTE  8'hAA  value of the primed entry
// PORTS
// - h_phi2                  in   1                    single clock; all state changes on its rising edge
// - h_rst_b                 in   1                    synchronous, active-low reset
// - h_flush                 in   1                    synchronous clear (Tube soft reset)
// - one_byte_mode           in   1                    1: single-byte latch semantics; 0: burst semantics
// - p_wr                    in   1                    parasite write strobe, one cycle per byte
// - p_data                  in   WIDTH                parasite write data
// - h_rd                    in   1                    host read/pop strobe, one cycle per byte
// - h_data                  out  WIDTH                head entry (show-ahead); last value held when empty
// - h_data_available        out  1                    host may pop
// - h_zero_bytes_available  out  1                    count==0
// - p_full                  out  1                    parasite must not write
// - h_count                 out  $clog2(DEPTH)+1      current occupancy, 0..DEPTH
// - overflow                out  1                    sticky: a write was rejected
// - underflow               out  1                    sticky: a pop was rejected
// BEHAVIOUR
// - Priority: reset > flush > push/pop.
// - Reset:
//   - RESET_PRIME=1: count=1, entry0=RESET_BYTE.
//   - RESET_PRIME=0: count=0.
//   - phase=FILL, overflow=0, underflow=0, pointers at 0.
// - Flush: count=0, phase=FILL, stickies cleared, pointers realigned. Storage contents are not cleared.
// - Accept rules, evaluated on pre-edge state:
//   - push accepted iff p_wr & !p_full.
//   - pop accepted iff h_rd & h_data_available.
//   - A rejected push drops its data and sets overflow. A rejected pop leaves h_data unchanged and sets underflow.
// - Simultaneous accepted push+pop: count unchanged, both pointers advance. Not reachable with legal flags; must still be correct.
// - Latency: a pushed byte is visible on h_data, h_count and the flags one cycle after the write edge. The next entry appears one cycle after a pop.
// - one_byte_mode=1:
//   - h_data_available = count>=1.
//   - p_full = count>=1.
//   - Phase is ignored.
// - Burst mode, states FILL and DRAIN:
//   - FILL: h_data_available=0; p_full = (count==DEPTH).
//   - FILL->DRAIN when post-edge count >= BURST.
//   - DRAIN: h_data_available=1; p_full=1.
//   - DRAIN->FILL when post-edge count==0.
// - Mode change mid-operation:
//   - Storage and count are kept.
//   - On entering burst mode, phase is reloaded from count: DRAIN if count>=BURST, else FILL.
// - h_zero_bytes_available = (count==0) in both modes.
// - Pointers wrap modulo DEPTH. count never exceeds DEPTH and never goes below 0.
// STRUCTURE
// - tube_defs.vh (shared include): PH_PHASE_FILL/PH_PHASE_DRAIN localparams, default RESET_BYTE.
// - Sub-module ph_fifo_store: storage array, write/read pointers, head mux. Ports: clk, rst_b, flush, push, pop, din, dout.
// - Top level owns count, phase FSM, mode logic and sticky errors.
// TESTING
// - Reset, RESET_PRIME=1, one_byte_mode=1 -> h_data=AA, available=1, p_full=1, count=1. Pop -> zero_bytes=1, p_full=0.
// - Burst mode, BURST=2: push 11 -> available=0, p_full=0. Push 22 -> available=1, p_full=1. Pop -> h_data=22, available still 1. Pop -> FILL, p_full=0.
// - DEPTH=4, BURST=4: push 01..04 -> h_data reads 01,02,03,04. Repeat three times to cover pointer wrap; no error flags set.
// - Write while p_full -> overflow=1, count unchanged. Pop while available=0 -> underflow=1. h_flush -> both cleared, count=0.
// - Two entries queued in one_byte_mode, then switch to burst mode -> phase=DRAIN, available=1. Switch back -> p_full=1.
// - Assert h_rst_b=0 mid-burst with p_wr=1 in the same cycle -> state equals the reset state; the write is ignored.

Source files
------------

// File: rtl/ph_burst_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ph_burst_fifo_pkg
// Shared definitions for the parasite-to-host burst FIFO:
//   - ph_phase_e            : burst-mode phase (FILL collects, DRAIN empties)
//   - PH_DEFAULT_RESET_BYTE : default value of the entry primed at reset
//   - ph_count_width()      : width of an occupancy counter holding 0..depth
// ---------------------------------------------------------------------------
package ph_burst_fifo_pkg;

  typedef enum logic {
    PH_PHASE_FILL  = 1'b0,
    PH_PHASE_DRAIN = 1'b1
  } ph_phase_e;

  localparam logic [7:0] PH_DEFAULT_RESET_BYTE = 8'hAA;

  // The counter must represent DEPTH itself, hence the extra bit.
  function automatic int ph_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ph_burst_fifo_if.sv
// ---------------------------------------------------------------------------
// ph_burst_fifo_if
// Bus between the parasite write port / host read port and the FIFO.
//   master : the environment (drives p_wr, p_data, h_rd; observes the rest)
//   slave  : the FIFO
// Signals:
//   p_wr, p_data            parasite write strobe and data
//   h_rd                    host pop strobe
//   h_data                  show-ahead head entry
//   h_data_available        host may pop
//   h_zero_bytes_available  occupancy is zero
//   p_full                  parasite must not write
//   h_count                 occupancy 0..DEPTH
//   overflow, underflow     sticky rejected-write / rejected-pop flags
// ---------------------------------------------------------------------------
interface ph_burst_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();
  import ph_burst_fifo_pkg::*;

  localparam int CW = ph_count_width(DEPTH);

  logic             p_wr;
  logic [WIDTH-1:0] p_data;
  logic             h_rd;
  logic [WIDTH-1:0] h_data;
  logic             h_data_available;
  logic             h_zero_bytes_available;
  logic             p_full;
  logic [CW-1:0]    h_count;
  logic             overflow;
  logic             underflow;

  modport master (
    output p_wr, p_data, h_rd,
    input  h_data, h_data_available, h_zero_bytes_available, p_full,
    input  h_count, overflow, underflow
  );

  modport slave (
    input  p_wr, p_data, h_rd,
    output h_data, h_data_available, h_zero_bytes_available, p_full,
    output h_count, overflow, underflow
  );

endinterface

// File: rtl/ph_fifo_store.sv
// ---------------------------------------------------------------------------
// ph_fifo_store
// Storage array, write/read pointers and show-ahead head mux.
// push/pop must already be qualified by the caller (accepted operations only).
// Ports:
//   clk    rising-edge clock
//   rst_b  synchronous active-low reset
//   flush  synchronous clear: pointers realigned to 0, storage untouched
//   push   write din at the tail
//   pop    advance the head
//   din    write data
//   dout   head entry; when empty, the last displayed value is held
// ---------------------------------------------------------------------------
module ph_fifo_store
  import ph_burst_fifo_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter int               RESET_PRIME = 1,
  parameter logic [WIDTH-1:0] RESET_BYTE  = WIDTH'(PH_DEFAULT_RESET_BYTE)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes empty from full; the low AW bits
  // index the array, so addressing wraps modulo DEPTH.
  typedef logic [AW:0] ptr_t;

  localparam ptr_t WR_RESET = (RESET_PRIME != 0) ? ptr_t'(1) : ptr_t'(0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wr_q, wr_d;
  ptr_t             rd_q, rd_d;
  logic [WIDTH-1:0] hold_q;
  logic             empty;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned -- otherwise synthesis infers a latch.
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = wr_q + ptr_t'(1);
    if (pop)  rd_d = rd_q + ptr_t'(1);
  end

  assign empty = (wr_q == rd_q);
  assign dout  = empty ? hold_q : mem_q[rd_q[AW-1:0]];

  // hold_q shadows whatever is on dout, so when the store drains (or is
  // flushed) the host keeps seeing the last value it was shown.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_b) begin
      wr_q   <= WR_RESET;
      rd_q   <= '0;
      hold_q <= (RESET_PRIME != 0) ? RESET_BYTE : '0;
    end else if (flush) begin
      wr_q   <= '0;
      rd_q   <= '0;
      hold_q <= dout;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      hold_q <= dout;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; only the primed
    // entry is loaded so it maps to plain RAM/flops without a reset tree.
    if (!rst_b) begin
      if (RESET_PRIME != 0) mem_q[0] <= RESET_BYTE;
    end else if (!flush && push) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/ph_burst_fifo.sv
// ---------------------------------------------------------------------------
// ph_burst_fifo
// Parasite-to-host data FIFO for Tube register 3 block transfers.
// one_byte_mode=1 behaves as a single-entry latch; one_byte_mode=0 adds
// burst hysteresis: the parasite may write until BURST entries are queued,
// then the host may read until the FIFO is fully drained.
// Ports:
//   h_phi2         clock, all state changes on its rising edge
//   h_rst_b        synchronous active-low reset (highest priority)
//   h_flush        synchronous clear (Tube soft reset)
//   one_byte_mode  1: latch semantics, 0: burst semantics
//   bus            ph_burst_fifo_if.slave: write/read strobes, data, flags,
//                  occupancy and sticky overflow/underflow
// ---------------------------------------------------------------------------
module ph_burst_fifo
  import ph_burst_fifo_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter int               BURST       = 2,
  parameter int               RESET_PRIME = 1,
  parameter logic [WIDTH-1:0] RESET_BYTE  = WIDTH'(PH_DEFAULT_RESET_BYTE)
) (
  input  logic h_phi2,
  input  logic h_rst_b,
  input  logic h_flush,
  input  logic one_byte_mode,
  ph_burst_fifo_if.slave bus
);

  localparam int CW = ph_count_width(DEPTH);

  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [CW-1:0] BURST_COUNT = CW'(BURST);
  localparam logic [CW-1:0] RESET_COUNT = (RESET_PRIME != 0) ? CW'(1) : CW'(0);

  logic [CW-1:0] count_q, count_d;
  ph_phase_e     phase_q, phase_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          avail;
  logic          full;
  logic          push;
  logic          pop;

  // -------------------------------------------------------------------------
  // Phase FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge h_phi2) begin
    if (!h_rst_b) begin
      phase_q <= PH_PHASE_FILL;
    end else if (h_flush) begin
      phase_q <= PH_PHASE_FILL;
    end else begin
      phase_q <= phase_d;
    end
  end

  // -------------------------------------------------------------------------
  // Phase FSM: next state
  // While in one-byte mode the phase simply follows the occupancy, so on the
  // first burst-mode cycle it already equals "count >= BURST" -- the reload
  // on entering burst mode needs no mode-edge detector.
  // -------------------------------------------------------------------------
  always_comb begin
    phase_d = phase_q;
    if (one_byte_mode) begin
      phase_d = (count_d >= BURST_COUNT) ? PH_PHASE_DRAIN : PH_PHASE_FILL;
    end else begin
      unique case (phase_q)
        PH_PHASE_FILL:  if (count_d >= BURST_COUNT) phase_d = PH_PHASE_DRAIN;
        PH_PHASE_DRAIN: if (count_d == '0)          phase_d = PH_PHASE_FILL;
        default:        phase_d = PH_PHASE_FILL;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Phase FSM: outputs (handshake flags, from pre-edge state)
  // -------------------------------------------------------------------------
  always_comb begin
    avail = 1'b0;
    full  = 1'b0;
    if (one_byte_mode) begin
      avail = (count_q != '0);
      full  = (count_q != '0);
    end else if (phase_q == PH_PHASE_DRAIN) begin
      avail = 1'b1;
      full  = 1'b1;
    end else begin
      avail = 1'b0;
      full  = (count_q == FULL_COUNT);
    end
  end

  assign push = bus.p_wr & ~full;
  assign pop  = bus.h_rd & avail;

  // -------------------------------------------------------------------------
  // Occupancy and sticky error flags
  // -------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (bus.p_wr & full);
    unf_d = unf_q | (bus.h_rd & ~avail);
  end

  always_ff @(posedge h_phi2) begin
    if (!h_rst_b) begin
      count_q <= RESET_COUNT;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (h_flush) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  ph_fifo_store #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .RESET_PRIME (RESET_PRIME),
    .RESET_BYTE  (RESET_BYTE)
  ) u_store (
    .clk   (h_phi2),
    .rst_b (h_rst_b),
    .flush (h_flush),
    .push  (push),
    .pop   (pop),
    .din   (bus.p_data),
    .dout  (bus.h_data)
  );

  assign bus.h_data_available       = avail;
  assign bus.p_full                 = full;
  assign bus.h_zero_bytes_available = (count_q == '0);
  assign bus.h_count                = count_q;
  assign bus.overflow               = ovf_q;
  assign bus.underflow              = unf_q;

endmodule

// File: tb/tb_ph_burst_fifo.sv
// ---------------------------------------------------------------------------
// tb_ph_burst_fifo
// Two FIFOs share one stimulus stream: dut_b2 (DEPTH 4, BURST 2, primed with
// AA at reset) and dut_b4 (DEPTH 4, BURST 4, empty at reset). Directed
// scenarios check fixed values on one of them; a randomized phase compares
// both against a queue-based reference model that runs on every edge.
// ---------------------------------------------------------------------------
module tb_ph_burst_fifo;

  logic       h_phi2 = 1'b0;
  logic       h_rst_b;
  logic       h_flush;
  logic       obm;
  logic       p_wr;
  logic       h_rd;
  logic [7:0] p_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 h_phi2 = ~h_phi2;

  ph_burst_fifo_if #(.WIDTH(8), .DEPTH(4)) bus2 ();
  ph_burst_fifo_if #(.WIDTH(8), .DEPTH(4)) bus4 ();

  assign bus2.p_wr = p_wr;  assign bus2.p_data = p_data;  assign bus2.h_rd = h_rd;
  assign bus4.p_wr = p_wr;  assign bus4.p_data = p_data;  assign bus4.h_rd = h_rd;

  ph_burst_fifo #(.WIDTH(8), .DEPTH(4), .BURST(2), .RESET_PRIME(1), .RESET_BYTE(8'hAA)) dut_b2 (
    .h_phi2(h_phi2), .h_rst_b(h_rst_b), .h_flush(h_flush), .one_byte_mode(obm), .bus(bus2));

  ph_burst_fifo #(.WIDTH(8), .DEPTH(4), .BURST(4), .RESET_PRIME(0), .RESET_BYTE(8'hAA)) dut_b4 (
    .h_phi2(h_phi2), .h_rst_b(h_rst_b), .h_flush(h_flush), .one_byte_mode(obm), .bus(bus4));

  // Observed outputs, indexed by instance (0: BURST 2, 1: BURST 4).
  logic [7:0] d_data  [2];
  logic [2:0] d_count [2];
  logic       d_av [2], d_full [2], d_zero [2], d_ov [2], d_un [2];

  assign d_data[0]  = bus2.h_data;            assign d_data[1]  = bus4.h_data;
  assign d_count[0] = bus2.h_count;           assign d_count[1] = bus4.h_count;
  assign d_av[0]    = bus2.h_data_available;  assign d_av[1]    = bus4.h_data_available;
  assign d_full[0]  = bus2.p_full;            assign d_full[1]  = bus4.p_full;
  assign d_zero[0]  = bus2.h_zero_bytes_available;
  assign d_zero[1]  = bus4.h_zero_bytes_available;
  assign d_ov[0]    = bus2.overflow;          assign d_ov[1]    = bus4.overflow;
  assign d_un[0]    = bus2.underflow;         assign d_un[1]    = bus4.underflow;

  // -------------------------------------------------------------------------
  // Reference model: a queue per instance plus the burst phase, evaluated
  // straight from the accept/phase rules on each rising edge.
  // -------------------------------------------------------------------------
  logic [7:0] mq [2][$];
  bit         m_drain    [2];
  bit         m_ov       [2];
  bit         m_un       [2];
  bit         m_shown_ok [2];
  logic [7:0] m_shown    [2];
  bit         m_prev_obm = 1'b0;
  bit         m_ph, m_av, m_fu;

  function automatic int burst_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  // Burst phase as seen now; re-derived from occupancy right after leaving
  // one-byte mode.
  function automatic bit phase_now(input int i);
    if (!obm && m_prev_obm) return (mq[i].size() >= burst_of(i));
    return m_drain[i];
  endfunction

  function automatic bit exp_avail(input int i);
    return obm ? (mq[i].size() != 0) : phase_now(i);
  endfunction

  function automatic bit exp_full(input int i);
    return obm ? (mq[i].size() != 0) : (phase_now(i) || mq[i].size() == 4);
  endfunction

  always @(posedge h_phi2) begin
    for (int i = 0; i < 2; i++) begin
      if (!h_rst_b) begin
        mq[i].delete();
        m_drain[i] = 1'b0;  m_ov[i] = 1'b0;  m_un[i] = 1'b0;
        if (i == 0) mq[i].push_back(8'hAA);
        else        m_shown_ok[i] = 1'b0;
      end else if (h_flush) begin
        mq[i].delete();
        m_drain[i] = 1'b0;  m_ov[i] = 1'b0;  m_un[i] = 1'b0;
      end else begin
        m_ph = phase_now(i);
        m_av = exp_avail(i);
        m_fu = exp_full(i);
        if (h_rd && !m_av) m_un[i] = 1'b1;
        if (p_wr && m_fu)  m_ov[i] = 1'b1;
        if (h_rd && m_av)  void'(mq[i].pop_front());
        if (p_wr && !m_fu) mq[i].push_back(p_data);
        m_drain[i] = m_ph;
        if (!obm) begin
          if (!m_ph && mq[i].size() >= burst_of(i)) m_drain[i] = 1'b1;
          else if (m_ph && mq[i].size() == 0)      m_drain[i] = 1'b0;
        end
      end
      if (mq[i].size() != 0) begin
        m_shown[i]    = mq[i][0];
        m_shown_ok[i] = 1'b1;
      end
    end
    m_prev_obm = obm;
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge h_phi2);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    p_wr = 1'b1;  p_data = b;  tick();  p_wr = 1'b0;
  endtask

  task automatic pop();
    h_rd = 1'b1;  tick();  h_rd = 1'b0;
  endtask

  task automatic flush_all();
    h_flush = 1'b1;  tick();  h_flush = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    h_rst_b = 1'b0;  obm = 1'b1;
    tick();  tick();
    h_rst_b = 1'b1;
    n_cmp++; if (bus2.h_data !== 8'hAA) begin n_bad++; $display("FAIL reset_data: got %0h want aa", bus2.h_data); end
    n_cmp++; if (bus2.h_data_available !== 1'b1) begin n_bad++; $display("FAIL reset_avail: got %0b want 1", bus2.h_data_available); end
    n_cmp++; if (bus2.p_full !== 1'b1) begin n_bad++; $display("FAIL reset_full: got %0b want 1", bus2.p_full); end
    n_cmp++; if (bus2.h_count !== 3'd1) begin n_bad++; $display("FAIL reset_count: got %0d want 1", bus2.h_count); end
    n_cmp++; if (bus2.overflow !== 1'b0 || bus2.underflow !== 1'b0) begin n_bad++; $display("FAIL reset_sticky: got %0b%0b want 00", bus2.overflow, bus2.underflow); end
    n_cmp++; if (bus4.h_count !== 3'd0 || bus4.h_zero_bytes_available !== 1'b1) begin n_bad++; $display("FAIL reset_noprime: got count %0d zero %0b want 0 1", bus4.h_count, bus4.h_zero_bytes_available); end
    pop();
    n_cmp++; if (bus2.h_zero_bytes_available !== 1'b1) begin n_bad++; $display("FAIL latch_pop_zero: got %0b want 1", bus2.h_zero_bytes_available); end
    n_cmp++; if (bus2.p_full !== 1'b0) begin n_bad++; $display("FAIL latch_pop_full: got %0b want 0", bus2.p_full); end
  endtask

  task automatic test_burst();
    obm = 1'b0;  flush_all();
    push(8'h11);
    n_cmp++; if (bus2.h_data_available !== 1'b0 || bus2.p_full !== 1'b0) begin n_bad++; $display("FAIL burst_one: got avail %0b full %0b want 0 0", bus2.h_data_available, bus2.p_full); end
    push(8'h22);
    n_cmp++; if (bus2.h_data_available !== 1'b1 || bus2.p_full !== 1'b1) begin n_bad++; $display("FAIL burst_two: got avail %0b full %0b want 1 1", bus2.h_data_available, bus2.p_full); end
    n_cmp++; if (bus2.h_data !== 8'h11) begin n_bad++; $display("FAIL burst_head: got %0h want 11", bus2.h_data); end
    pop();
    n_cmp++; if (bus2.h_data !== 8'h22 || bus2.h_data_available !== 1'b1) begin n_bad++; $display("FAIL burst_pop1: got data %0h avail %0b want 22 1", bus2.h_data, bus2.h_data_available); end
    pop();
    n_cmp++; if (bus2.p_full !== 1'b0 || bus2.h_data_available !== 1'b0 || bus2.h_zero_bytes_available !== 1'b1) begin n_bad++; $display("FAIL burst_drained: got full %0b avail %0b zero %0b want 0 0 1", bus2.p_full, bus2.h_data_available, bus2.h_zero_bytes_available); end
    n_cmp++; if (bus2.h_data !== 8'h22) begin n_bad++; $display("FAIL burst_hold: got %0h want 22", bus2.h_data); end
  endtask

  task automatic test_wrap();
    obm = 1'b0;  flush_all();
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 1; k <= 4; k++) push(8'(k));
      n_cmp++; if (bus4.h_count !== 3'd4 || bus4.h_data_available !== 1'b1) begin n_bad++; $display("FAIL wrap_full rep %0d: got count %0d avail %0b want 4 1", rep, bus4.h_count, bus4.h_data_available); end
      for (int k = 1; k <= 4; k++) begin
        n_cmp++; if (bus4.h_data !== 8'(k)) begin n_bad++; $display("FAIL wrap_data rep %0d: got %0h want %0h", rep, bus4.h_data, k); end
        pop();
      end
      n_cmp++; if (bus4.h_data_available !== 1'b0 || bus4.p_full !== 1'b0) begin n_bad++; $display("FAIL wrap_refill rep %0d: got avail %0b full %0b want 0 0", rep, bus4.h_data_available, bus4.p_full); end
    end
    n_cmp++; if (bus4.overflow !== 1'b0 || bus4.underflow !== 1'b0) begin n_bad++; $display("FAIL wrap_sticky: got %0b%0b want 00", bus4.overflow, bus4.underflow); end
  endtask

  task automatic test_errors();
    obm = 1'b0;  flush_all();
    pop();
    n_cmp++; if (bus2.underflow !== 1'b1 || bus2.h_count !== 3'd0) begin n_bad++; $display("FAIL err_underflow: got unf %0b count %0d want 1 0", bus2.underflow, bus2.h_count); end
    push(8'h33);  push(8'h44);  push(8'h55);
    n_cmp++; if (bus2.overflow !== 1'b1 || bus2.h_count !== 3'd2) begin n_bad++; $display("FAIL err_overflow: got ovf %0b count %0d want 1 2", bus2.overflow, bus2.h_count); end
    n_cmp++; if (bus2.h_data !== 8'h33) begin n_bad++; $display("FAIL err_head: got %0h want 33", bus2.h_data); end
    flush_all();
    n_cmp++; if (bus2.overflow !== 1'b0 || bus2.underflow !== 1'b0 || bus2.h_count !== 3'd0) begin n_bad++; $display("FAIL err_flush: got ovf %0b unf %0b count %0d want 0 0 0", bus2.overflow, bus2.underflow, bus2.h_count); end
  endtask

  task automatic test_mode_switch();
    obm = 1'b0;  flush_all();
    push(8'h11);  push(8'h22);
    obm = 1'b1;  tick();
    n_cmp++; if (bus2.h_data_available !== 1'b1 || bus2.p_full !== 1'b1) begin n_bad++; $display("FAIL mode_latch: got avail %0b full %0b want 1 1", bus2.h_data_available, bus2.p_full); end
    obm = 1'b0;  tick();
    n_cmp++; if (bus2.h_data_available !== 1'b1 || bus2.h_count !== 3'd2) begin n_bad++; $display("FAIL mode_to_drain: got avail %0b count %0d want 1 2", bus2.h_data_available, bus2.h_count); end
    obm = 1'b1;  tick();
    n_cmp++; if (bus2.p_full !== 1'b1) begin n_bad++; $display("FAIL mode_back_full: got %0b want 1", bus2.p_full); end
    // One entry left in DRAIN; a round trip through one-byte mode reloads FILL.
    obm = 1'b0;  pop();
    n_cmp++; if (bus2.h_data_available !== 1'b1 || bus2.h_count !== 3'd1) begin n_bad++; $display("FAIL mode_partial: got avail %0b count %0d want 1 1", bus2.h_data_available, bus2.h_count); end
    obm = 1'b1;  tick();
    obm = 1'b0;  tick();
    n_cmp++; if (bus2.h_data_available !== 1'b0 || bus2.p_full !== 1'b0) begin n_bad++; $display("FAIL mode_reload_fill: got avail %0b full %0b want 0 0", bus2.h_data_available, bus2.p_full); end
  endtask

  task automatic test_reset_mid_burst();
    obm = 1'b0;  flush_all();
    push(8'h11);
    h_rst_b = 1'b0;  p_wr = 1'b1;  p_data = 8'h55;
    tick();
    h_rst_b = 1'b1;  p_wr = 1'b0;
    n_cmp++; if (bus2.h_count !== 3'd1 || bus2.h_data !== 8'hAA) begin n_bad++; $display("FAIL rstmid_state: got count %0d data %0h want 1 aa", bus2.h_count, bus2.h_data); end
    n_cmp++; if (bus2.h_data_available !== 1'b0 || bus2.p_full !== 1'b0) begin n_bad++; $display("FAIL rstmid_flags: got avail %0b full %0b want 0 0", bus2.h_data_available, bus2.p_full); end
    n_cmp++; if (bus4.h_count !== 3'd0) begin n_bad++; $display("FAIL rstmid_noprime: got %0d want 0", bus4.h_count); end
    tick();
    n_cmp++; if (bus2.h_count !== 3'd1 || bus2.overflow !== 1'b0) begin n_bad++; $display("FAIL rstmid_settled: got count %0d ovf %0b want 1 0", bus2.h_count, bus2.overflow); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      h_rst_b = ($urandom_range(0, 199) != 0);
      h_flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 15) == 0) obm = ~obm;
      p_wr    = 1'($urandom_range(0, 1));
      h_rd    = ($urandom_range(0, 9) < 4);
      p_data  = 8'($urandom);
      tick();
      for (int i = 0; i < 2; i++) begin
        n_cmp++; if (d_count[i] !== 3'(mq[i].size())) begin n_bad++; $display("FAIL rnd_count[%0d] cyc %0d: got %0d want %0d", i, cyc, d_count[i], mq[i].size()); end
        n_cmp++; if (d_av[i] !== exp_avail(i)) begin n_bad++; $display("FAIL rnd_avail[%0d] cyc %0d: got %0b want %0b", i, cyc, d_av[i], exp_avail(i)); end
        n_cmp++; if (d_full[i] !== exp_full(i)) begin n_bad++; $display("FAIL rnd_full[%0d] cyc %0d: got %0b want %0b", i, cyc, d_full[i], exp_full(i)); end
        n_cmp++; if (d_zero[i] !== (mq[i].size() == 0)) begin n_bad++; $display("FAIL rnd_zero[%0d] cyc %0d: got %0b want %0b", i, cyc, d_zero[i], mq[i].size() == 0); end
        n_cmp++; if (d_ov[i] !== m_ov[i] || d_un[i] !== m_un[i]) begin n_bad++; $display("FAIL rnd_sticky[%0d] cyc %0d: got %0b%0b want %0b%0b", i, cyc, d_ov[i], d_un[i], m_ov[i], m_un[i]); end
        if (m_shown_ok[i]) begin
          n_cmp++; if (d_data[i] !== m_shown[i]) begin n_bad++; $display("FAIL rnd_data[%0d] cyc %0d: got %0h want %0h", i, cyc, d_data[i], m_shown[i]); end
        end
      end
    end
    h_rst_b = 1'b1;  h_flush = 1'b0;  p_wr = 1'b0;  h_rd = 1'b0;
    tick();
  endtask

  initial begin
    h_rst_b = 1'b0;  h_flush = 1'b0;  obm = 1'b1;
    p_wr    = 1'b0;  h_rd    = 1'b0;  p_data = 8'h00;
    test_reset();
    test_burst();
    test_wrap();
    test_errors();
    test_mode_switch();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
